// File: rtl/dsp_preadd_mac.sv
// ----------------------------------------------------------------------------
// dsp_preadd_mac
//
// Pipelined pre-adder / multiplier / post-adder DSP slice computing one
// (B +/- D) * A operation per enabled clock, followed by a selectable
// post-add stage.
//
//   S1  register operands, mode bits and in_valid
//   S2  pre = b + d  or  pre = (d - b) mod 2^(B_W+1)      (B_W+1 bits)
//   S3  m   = a * pre                                    (A_W+B_W+1 bits)
//   S4  p   = m + c | p + m | c - m | m   (mod 2^P_W), ovf = carry/borrow
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears every register
//   ce         clock enable for every register, including valid bits and p
//   in_valid   operands and mode are valid this cycle
//   a          multiplier operand, unsigned, A_W bits
//   b, d       pre-adder operands, unsigned, B_W bits
//   c          post-adder operand, unsigned, C_W bits (zero-extended to P_W)
//   pre_sub    0: pre = b + d, 1: pre = d - b
//   opmode     00: m + c, 01: p + m, 10: c - m, 11: m
//   p          result register, P_W bits
//   out_valid  p holds a new result this cycle
//   ovf        carry (00/01) or borrow (10) of the result in p; 0 for 11
//
// Latency is 4 enabled clocks, throughput one op per enabled clock.
// P_W must be >= A_W+B_W+1 and >= C_W.
// ----------------------------------------------------------------------------
module dsp_preadd_mac #(
   parameter int A_W = 18,
   parameter int B_W = 18,
   parameter int C_W = 48,
   parameter int P_W = 48
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ce,
   input  logic           in_valid,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   input  logic [B_W-1:0] d,
   input  logic [C_W-1:0] c,
   input  logic           pre_sub,
   input  logic [1:0]     opmode,
   output logic [P_W-1:0] p,
   output logic           out_valid,
   output logic           ovf
);

   localparam int PRE_W = B_W + 1;
   localparam int M_W   = A_W + B_W + 1;

   localparam logic [1:0] MODE_ADD_C = 2'b00;
   localparam logic [1:0] MODE_ACC   = 2'b01;
   localparam logic [1:0] MODE_SUB_C = 2'b10;
   localparam logic [1:0] MODE_PASS  = 2'b11;

   // One valid bit per stage; bit 3 is the S4 (output) stage.
   logic [3:0]       vld_reg;

   // S1
   logic [A_W-1:0]   a_s1_reg;
   logic [B_W-1:0]   b_s1_reg;
   logic [B_W-1:0]   d_s1_reg;
   logic [C_W-1:0]   c_s1_reg;
   logic             pre_sub_s1_reg;
   logic [1:0]       opmode_s1_reg;

   // S2
   logic [A_W-1:0]   a_s2_reg;
   logic [PRE_W-1:0] pre_s2_reg;
   logic [C_W-1:0]   c_s2_reg;
   logic [1:0]       opmode_s2_reg;
   logic [PRE_W-1:0] pre_next;

   // S3
   logic [M_W-1:0]   m_s3_reg;
   logic [C_W-1:0]   c_s3_reg;
   logic [1:0]       opmode_s3_reg;
   logic [M_W-1:0]   m_next;

   // S4
   logic [P_W-1:0]   p_reg;
   logic             ovf_reg;
   logic [P_W-1:0]   m_ext;
   logic [P_W-1:0]   c_ext;
   logic [P_W:0]     post_sum;
   logic [P_W-1:0]   p_next;
   logic             ovf_next;

   // Pre-adder: operands widened by one bit so the add keeps its carry and
   // the subtract wraps naturally modulo 2^(B_W+1).
   always_comb begin
      if (pre_sub_s1_reg) begin
         pre_next = {1'b0, d_s1_reg} - {1'b0, b_s1_reg};
      end else begin
         pre_next = {1'b0, b_s1_reg} + {1'b0, d_s1_reg};
      end
   end

   // Full-precision unsigned product.
   assign m_next = M_W'(a_s2_reg) * M_W'(pre_s2_reg);

   assign m_ext = P_W'(m_s3_reg);
   assign c_ext = P_W'(c_s3_reg);

   // Post-adder computed one bit wider than p: the extra MSB is the carry
   // for the add modes and the borrow (m > c) for the subtract mode.
   always_comb begin
      post_sum = '0;
      case (opmode_s3_reg)
         MODE_ADD_C: post_sum = {1'b0, m_ext} + {1'b0, c_ext};
         MODE_ACC:   post_sum = {1'b0, p_reg} + {1'b0, m_ext};
         MODE_SUB_C: post_sum = {1'b0, c_ext} - {1'b0, m_ext};
         MODE_PASS:  post_sum = {1'b0, m_ext};
         default:    post_sum = '0;
      endcase
   end

   assign p_next   = post_sum[P_W-1:0];
   assign ovf_next = post_sum[P_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_reg        <= '0;
         a_s1_reg       <= '0;
         b_s1_reg       <= '0;
         d_s1_reg       <= '0;
         c_s1_reg       <= '0;
         pre_sub_s1_reg <= 1'b0;
         opmode_s1_reg  <= '0;
         a_s2_reg       <= '0;
         pre_s2_reg     <= '0;
         c_s2_reg       <= '0;
         opmode_s2_reg  <= '0;
         m_s3_reg       <= '0;
         c_s3_reg       <= '0;
         opmode_s3_reg  <= '0;
         p_reg          <= '0;
         ovf_reg        <= 1'b0;
      end else if (ce) begin
         vld_reg        <= {vld_reg[2:0], in_valid};

         // Data stages load every enabled cycle; bubbles carry don't-care
         // data that is never committed because their valid bit is low.
         a_s1_reg       <= a;
         b_s1_reg       <= b;
         d_s1_reg       <= d;
         c_s1_reg       <= c;
         pre_sub_s1_reg <= pre_sub;
         opmode_s1_reg  <= opmode;

         a_s2_reg       <= a_s1_reg;
         pre_s2_reg     <= pre_next;
         c_s2_reg       <= c_s1_reg;
         opmode_s2_reg  <= opmode_s1_reg;

         m_s3_reg       <= m_next;
         c_s3_reg       <= c_s2_reg;
         opmode_s3_reg  <= opmode_s2_reg;

         // p and ovf only change for a real op, so accumulation always sees
         // the most recent result regardless of intervening bubbles.
         if (vld_reg[2]) begin
            p_reg   <= p_next;
            ovf_reg <= ovf_next;
         end
      end
   end

   assign p         = p_reg;
   assign ovf       = ovf_reg;
   assign out_valid = vld_reg[3];

endmodule

// File: doc/dsp_preadd_mac.md
# dsp_preadd_mac

Parametrised pre-adder / multiplier / post-adder DSP slice with valid tracking, clock enable and runtime-selectable arithmetic mode. It is the next-generation replacement for the fixed 18×18+48 DSP block. It adds configurable widths, pre-add/pre-subtract, accumulate and subtract post-modes, and an overflow flag. It sits in datapath front-ends (filters, MAC chains) wherever one (B±D)·A op per clock is required.

## Interface
- A_W, default 18: width of operand a.
- B_W, default 18: width of operands b and d.
- C_W, default 48: width of operand c.
- P_W, default 48: width of result p. Must be ≥ A_W+B_W+1 and ≥ C_W.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- ce  input  1  clock enable for all pipeline registers, including valid bits.
- in_valid  input  1  operands and mode are valid this cycle.
- a  input  A_W  multiplier operand, unsigned.
- b  input  B_W  pre-adder operand, unsigned.
- d  input  B_W  pre-adder operand, unsigned.
- c  input  C_W  post-adder operand, unsigned.
- pre_sub  input  1  0: pre = b+d; 1: pre = d−b.
- opmode  input  2  post-adder mode:
  - 00: p = m+c
  - 01: p = p+m (accumulate)
  - 10: p = c−m
  - 11: p = m
- p  output  P_W  result register.
- out_valid  output  1  p holds a new result this cycle.
- ovf  output  1  overflow/borrow of the result currently presented. Qualified by out_valid.

## Operation
- Four-stage pipeline, each stage carrying its own valid bit. Stage data advances only when ce=1.
  - S1: register a, b, d, c, pre_sub, opmode, in_valid.
  - S2: pre-adder, B_W+1 bits, no truncation.
    - Add: pre = b+d, full carry kept.
    - Subtract: pre = (d−b) mod 2^(B_W+1).
  - S3: multiplier, m = a·pre, A_W+B_W+1 bits, zero-extended to P_W.
  - S4: post-adder into p, computed mod 2^P_W.
    - ovf = carry-out for modes 00 and 01.
    - ovf = borrow (m > c) for mode 10.
    - ovf = 0 for mode 11.
- c is zero-extended to P_W.
- Accumulate (01) uses the current contents of p, regardless of the previous op's mode. Back-to-back accumulates therefore chain, each using the immediately preceding result.
- S4 stage valid=0: p and ovf hold their values; out_valid=0.
- Ops with in_valid=0 propagate as bubbles. They never modify p.
- No backpressure: a result is presented for exactly one cycle with out_valid=1. p keeps the value afterwards.

## Timing
- Latency: 4 enabled clocks. An op sampled at edge N (ce=1, in_valid=1) gives p/out_valid valid after edge N+3, i.e. at the 4th enabled edge including N.
- Throughput: one op per enabled clock.
- ce=0: every register, including valid bits and p, holds. out_valid stays at its held value. Latency extends by exactly the number of ce=0 cycles.
- Reset (rst_n=0) takes effect immediately, without a clock edge:
  - All stage registers, valid bits, p, out_valid and ovf go to 0.
  - In-flight ops are discarded and no result is produced for them.
  - After rst_n rises, the first op is sampled on the next enabled edge.
- Reset has priority over ce.
- Mode changes take effect per op. Mode travels with its operands, so mixing modes back-to-back is legal.

## Test plan
- Reset mid-flight: issue ops, then pull rst_n low between edges.
  - Required: p=0, out_valid=0 and ovf=0 immediately.
  - Required: no stale result appears after release.
- Basic, mode 00: a=3, b=5, d=7, c=10, pre_sub=0.
  - Required: p=46, out_valid=1 exactly 4 enabled edges later, ovf=0.
  - Also required: 100 random ops checked against a model.
- Full-width pre-add: b=d=18'h3FFFF, a=1, c=0, mode 00.
  - Required: p=48'h7FFFE (carry not truncated).
  - Then pre_sub=1 with b=3, d=1, a=1, mode 11: p=19'h7FFFE.
- Accumulate chain: after reset, three back-to-back mode-01 ops with a=2, b=1, d=1.
  - Required: p=4, 8, 12 on consecutive cycles, out_valid high for 3 cycles.
- Subtract borrow: mode 10, c=5, a=1, b=3, d=4.
  - Required: m=7, p=48'hFFFF_FFFF_FFFE, ovf=1.
  - With c=9: p=2, ovf=0.
- Clock enable: drop ce for 3 cycles while an op sits in S2.
  - Required: out_valid delayed by exactly 3 cycles, result value unchanged.
  - Required: p and out_valid frozen while ce=0.
